edge_event_arbiter: RTL
=======================

EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 Parameter CHANNELS, default 4: number of monitored input lines.
REQ-002 Parameter IDX_WIDTH, default 2: width of channel index; SHALL equal ceil(log2(CHANNELS)).
REQ-003 Parameter RISE_DETECTOR, default 1: 1 detects rising edges, 0 detects falling edges, all channels.
REQ-004 i_clk  input  1  single clock; all state updates on posedge.
REQ-005 i_reset  input  1  asynchronous, active-high reset.
REQ-006 i_lines  input  CHANNELS  asynchronous external lines, one per channel.
REQ-007 i_enable  input  CHANNELS  per-channel edge capture enable.
REQ-008 i_ready  input  1  consumer accepts the offered event.
REQ-009 i_clear_overflow  input  1  clears all overflow flags.
REQ-010 o_valid  output  1  an event is offered on o_channel.
REQ-011 o_channel  output  IDX_WIDTH  index of the offered channel.
REQ-012 o_pending  output  CHANNELS  per-channel captured-not-yet-granted flags.
REQ-013 o_overflow  output  CHANNELS  sticky per-channel lost-event flags.

Function
REQ-014 Each i_lines bit SHALL pass a 2-flop synchronizer, then a previous-value flop; detection compares synchronized value to previous value.
REQ-015 Edge SHALL be sync=1,prev=0 when RISE_DETECTOR=1; sync=0,prev=1 when RISE_DETECTOR=0.
REQ-016 Latency: line changing before posedge k SHALL set o_pending at posedge k+2 (visible cycle after k+2).
REQ-017 Edge on a channel with i_enable=0 SHALL be discarded; existing pending bit of a disabled channel SHALL be retained but not granted until re-enabled.
REQ-018 Edge on an enabled channel whose pending bit is already set and not being cleared that cycle SHALL set its o_overflow bit; pending stays set.
REQ-019 Edge in the same cycle its pending bit is cleared by a grant SHALL leave pending set; no overflow.
REQ-020 FSM states IDLE and OFFER; reset state IDLE.
REQ-021 IDLE: if any (o_pending & i_enable) bit set, SHALL select winner, register o_channel, clear winner's pending bit, go to OFFER; else stay IDLE.
REQ-022 OFFER: o_valid=1; o_channel SHALL hold stable until i_ready sampled high at a posedge, then go IDLE.
REQ-023 o_valid SHALL be 0 in IDLE; max throughput one event per 2 cycles.
REQ-024 Round-robin: search starts at last granted index +1, wraps CHANNELS-1 -> 0; last-granted pointer updates on each grant.
REQ-025 i_clear_overflow=1 SHALL clear all o_overflow bits at next posedge; a new overflow in the same cycle SHALL win (bit set).
REQ-026 Edges continue to be captured during OFFER.

Reset
REQ-027 i_reset=1 SHALL asynchronously clear synchronizers, previous-value flops, o_pending, o_overflow, o_valid, o_channel to 0 and FSM to IDLE.
REQ-028 Last-granted pointer SHALL reset to CHANNELS-1, so channel 0 wins first.
REQ-029 Reset asserted in OFFER SHALL drop o_valid immediately; offered event is lost without overflow.
REQ-030 With RISE_DETECTOR=1, a line held high through reset release SHALL produce one rising event; with RISE_DETECTOR=0, no event.

Verification
REQ-031 Single rise on ch2, i_enable=4'b1111, i_ready=1 -> o_pending[2] set 2 cycles later, then o_valid=1, o_channel=2 for one cycle, o_pending=0.
REQ-032 Simultaneous rises ch0,ch1,ch3 after reset, i_ready=1 -> grants in order 0,1,3; each o_valid pulse separated by one IDLE cycle.
REQ-033 i_ready=0 while ch1 offered, second rise on ch1 -> o_channel stays 1, o_pending[1]=1, o_overflow=0; third rise -> o_overflow[1]=1.
REQ-034 i_enable=4'b1101, rise on ch1 -> o_pending stays 0, o_valid never asserts.
REQ-035 o_overflow[0]=1, pulse i_clear_overflow -> o_overflow=0 next cycle; pulse coincident with new overflow on ch0 -> o_overflow[0]=1.
REQ-036 RISE_DETECTOR=0, toggle ch0 every 2 cycles 10 times -> exactly 5 events granted on channel 0; assert i_reset mid-OFFER -> o_valid=0 same cycle.

Source files
------------

// File: rtl/edge_event_arbiter.sv
// rtl/edge_event_arbiter.sv - edge capture on async lines with round-robin single-event offer
module edge_event_arbiter #(
  parameter int CHANNELS      = 4,
  parameter int IDX_WIDTH     = 2,
  parameter int RISE_DETECTOR = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [CHANNELS-1:0]  i_lines,
  input  logic [CHANNELS-1:0]  i_enable,
  input  logic                 i_ready,
  input  logic                 i_clear_overflow,
  output logic                 o_valid,
  output logic [IDX_WIDTH-1:0] o_channel,
  output logic [CHANNELS-1:0]  o_pending,
  output logic [CHANNELS-1:0]  o_overflow
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t                state;
  state_t                state_next;
  logic [CHANNELS-1:0]   sync1;
  logic [CHANNELS-1:0]   sync2;
  logic [CHANNELS-1:0]   prev;
  logic [CHANNELS-1:0]   edge_det;
  logic [CHANNELS-1:0]   capture;
  logic [CHANNELS-1:0]   req;
  logic [CHANNELS-1:0]   grant;
  logic [IDX_WIDTH-1:0]  last_grant;
  logic [IDX_WIDTH-1:0]  winner;
  logic [IDX_WIDTH-1:0]  cand;
  logic                  found;
  logic                  load;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= i_lines;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign edge_det = (RISE_DETECTOR != 0) ? (sync2 & ~prev) : (~sync2 & prev);
  assign capture  = edge_det & i_enable;
  assign req      = o_pending & i_enable;

  // Round-robin: first requester strictly after the last granted index, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      cand = IDX_WIDTH'((int'(last_grant) + i) % CHANNELS);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant      = '0;
    load       = 1'b0;
    o_valid    = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_next = OFFER;
          grant      = {{(CHANNELS-1){1'b0}}, 1'b1} << winner;
          load       = 1'b1;
        end
      end
      OFFER: begin
        o_valid = 1'b1;
        if (i_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_channel  <= '0;
      last_grant <= IDX_WIDTH'(CHANNELS - 1);
    end else if (load) begin
      o_channel  <= winner;
      last_grant <= winner;
    end
  end

  // An edge landing on the grant cycle re-arms pending instead of counting as lost.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_pending  <= '0;
      o_overflow <= '0;
    end else begin
      o_pending  <= (o_pending & ~grant) | capture;
      o_overflow <= (i_clear_overflow ? '0 : o_overflow) | (capture & o_pending & ~grant);
    end
  end

endmodule
